// File: rtl/frame_sync_pixel_unpacker.sv
// -----------------------------------------------------------------------------
// frame_sync_pixel_unpacker
//
// Display-side stage in the pixel clock domain. It takes 128-bit chunks
// (8 x 16-bit pixels) from the controller->pixel clock-domain FIFO and emits
// one pixel per active HDMI draw cycle. The chunk stream is frame-locked to
// the raster using chunk_tlast. Underflow and misalignment are detected. After
// an error the rest of the frame is dropped and the stage re-locks on the next
// frame.
//
// Ports
//   clk_pixel      in   1    pixel clock (sole clock)
//   sys_rst_pixel  in   1    synchronous, active-high reset
//   chunk_tvalid   in   1    AXIS chunk valid from the FIFO
//   chunk_tready   out  1    AXIS chunk ready (combinational, never uses tvalid)
//   chunk_tdata    in   128  pixel 0 = [15:0] ... pixel 7 = [127:112]
//   chunk_tlast    in   1    marks the last chunk of a frame
//   active_draw    in   1    HDMI active region this cycle
//   h_count        in   11   HDMI horizontal count
//   v_count        in   10   HDMI vertical count
//   pixel_out      out  16   registered pixel to the display pipeline
//   pixel_locked   out  1    registered; 1 when pixel_out carries frame data
//   resync_count   out  16   saturating count of lock losses since reset
// -----------------------------------------------------------------------------
module frame_sync_pixel_unpacker #(
    parameter int          WIDTH      = 1280,
    parameter int          HEIGHT     = 720,
    parameter logic [15:0] FILL_COLOR = 16'h2277
) (
    input  logic         clk_pixel,
    input  logic         sys_rst_pixel,
    input  logic         chunk_tvalid,
    output logic         chunk_tready,
    input  logic [127:0] chunk_tdata,
    input  logic         chunk_tlast,
    input  logic         active_draw,
    input  logic [10:0]  h_count,
    input  logic [9:0]   v_count,
    output logic [15:0]  pixel_out,
    output logic         pixel_locked,
    output logic [15:0]  resync_count
);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        ARMED     = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
    localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

    state_t       state_reg;
    logic [127:0] buf_reg;
    logic         buf_valid_reg;
    logic         buf_last_reg;
    logic [2:0]   idx_reg;
    logic [15:0]  pixel_reg;
    logic         locked_reg;
    logic [15:0]  resync_reg;

    // Per-lane view of the chunk register so idx can select a pixel directly.
    logic [15:0] lane [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane[gi] = buf_reg[gi*16 +: 16];
        end
    endgenerate

    logic        xfer;
    logic        frame_start;
    logic        frame_end;
    logic        idx_last;
    logic        lose_lock;
    logic [15:0] cur_pixel;

    always_comb begin
        frame_start = active_draw && (h_count == 11'd0) && (v_count == 10'd0);
        frame_end   = (h_count == H_LAST) && (v_count == V_LAST);
        idx_last    = (idx_reg == 3'd7);
        cur_pixel   = lane[idx_reg];

        chunk_tready = 1'b0;
        case (state_reg)
            SYNC_WAIT: chunk_tready = 1'b1;
            ARMED:     chunk_tready = !buf_valid_reg;
            // The next chunk may only land when the last pixel of the current
            // one is being consumed, or when the buffer already ran dry.
            RUN:       chunk_tready = !buf_valid_reg || (active_draw && idx_last);
            default:   chunk_tready = 1'b0;
        endcase
        xfer = chunk_tvalid && chunk_tready;

        // In RUN an active cycle breaks lock on underflow, on reaching frame
        // end anywhere but the last pixel of the tlast chunk, or on finishing
        // the tlast chunk before the raster reaches frame end.
        lose_lock = 1'b0;
        if (state_reg == RUN && active_draw) begin
            if (!buf_valid_reg) begin
                lose_lock = 1'b1;
            end else if (frame_end) begin
                lose_lock = !(idx_last && buf_last_reg);
            end else begin
                lose_lock = idx_last && buf_last_reg;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            state_reg     <= SYNC_WAIT;
            buf_reg       <= '0;
            buf_valid_reg <= 1'b0;
            buf_last_reg  <= 1'b0;
            idx_reg       <= 3'd0;
            pixel_reg     <= FILL_COLOR;
            locked_reg    <= 1'b0;
            resync_reg    <= 16'd0;
        end else begin
            pixel_reg  <= FILL_COLOR;
            locked_reg <= 1'b0;

            case (state_reg)
                SYNC_WAIT: begin
                    // Drain until the end-of-frame chunk goes by.
                    buf_valid_reg <= 1'b0;
                    idx_reg       <= 3'd0;
                    if (xfer && chunk_tlast) begin
                        state_reg <= ARMED;
                    end
                end

                ARMED: begin
                    if (xfer) begin
                        buf_reg       <= chunk_tdata;
                        buf_last_reg  <= chunk_tlast;
                        buf_valid_reg <= 1'b1;
                        idx_reg       <= 3'd0;
                    end else if (frame_start && buf_valid_reg) begin
                        // The frame-start cycle already consumes pixel 0.
                        state_reg  <= RUN;
                        pixel_reg  <= cur_pixel;
                        locked_reg <= 1'b1;
                        idx_reg    <= 3'd1;
                    end
                end

                RUN: begin
                    if (lose_lock) begin
                        state_reg     <= SYNC_WAIT;
                        buf_valid_reg <= 1'b0;
                        idx_reg       <= 3'd0;
                        if (resync_reg != 16'hFFFF) begin
                            resync_reg <= resync_reg + 16'd1;
                        end
                        // A misaligned pixel still came from the buffer.
                        if (buf_valid_reg) begin
                            pixel_reg  <= cur_pixel;
                            locked_reg <= 1'b1;
                        end
                    end else if (active_draw) begin
                        pixel_reg  <= cur_pixel;
                        locked_reg <= 1'b1;
                        if (idx_last) begin
                            if (frame_end) begin
                                state_reg <= ARMED;
                            end
                            if (xfer) begin
                                buf_reg       <= chunk_tdata;
                                buf_last_reg  <= chunk_tlast;
                                buf_valid_reg <= 1'b1;
                            end else begin
                                buf_valid_reg <= 1'b0;
                            end
                            idx_reg <= 3'd0;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end else if (xfer) begin
                        // Buffer ran dry at a chunk boundary; refill in blanking.
                        buf_reg       <= chunk_tdata;
                        buf_last_reg  <= chunk_tlast;
                        buf_valid_reg <= 1'b1;
                        idx_reg       <= 3'd0;
                    end
                end

                default: begin
                    state_reg     <= SYNC_WAIT;
                    buf_valid_reg <= 1'b0;
                    idx_reg       <= 3'd0;
                end
            endcase
        end
    end

    assign pixel_out    = pixel_reg;
    assign pixel_locked = locked_reg;
    assign resync_count = resync_reg;

endmodule

// File: tb/tb_frame_sync_pixel_unpacker.sv
// -----------------------------------------------------------------------------
// tb_frame_sync_pixel_unpacker
//
// Drives a small raster (32x4 active, 40x6 total) and a continuous chunk
// source, and checks every output cycle against a pixel-queue reference model
// of the frame-lock rules, plus per-scenario expectations.
// -----------------------------------------------------------------------------
module tb_frame_sync_pixel_unpacker;

    localparam int W       = 32;
    localparam int H       = 4;
    localparam int HT      = 40;
    localparam int VT      = 6;
    localparam int CPF     = W * H / 8;
    localparam int STALL_N = 40;
    localparam int PAUSE_N = 370;
    localparam int GUARD   = 5000;
    localparam logic [15:0] FILL = 16'h2277;

    logic         clk_pixel = 1'b0;
    logic         sys_rst_pixel = 1'b1;
    logic         chunk_tvalid = 1'b0;
    logic         chunk_tready;
    logic [127:0] chunk_tdata = '0;
    logic         chunk_tlast = 1'b0;
    logic         active_draw = 1'b0;
    logic [10:0]  h_count = '0;
    logic [9:0]   v_count = '0;
    logic [15:0]  pixel_out;
    logic         pixel_locked;
    logic [15:0]  resync_count;

    always #5 clk_pixel = ~clk_pixel;

    frame_sync_pixel_unpacker #(
        .WIDTH(W), .HEIGHT(H), .FILL_COLOR(FILL)
    ) dut (
        .clk_pixel    (clk_pixel),
        .sys_rst_pixel(sys_rst_pixel),
        .chunk_tvalid (chunk_tvalid),
        .chunk_tready (chunk_tready),
        .chunk_tdata  (chunk_tdata),
        .chunk_tlast  (chunk_tlast),
        .active_draw  (active_draw),
        .h_count      (h_count),
        .v_count      (v_count),
        .pixel_out    (pixel_out),
        .pixel_locked (pixel_locked),
        .resync_count (resync_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of pending pixels, each tagged when it is the
    // final pixel of a frame.
    typedef struct packed { logic [15:0] val; logic last; } pix_t;
    typedef enum int { M_HUNT, M_ARM, M_RUN } mstate_t;
    pix_t        mq[$];
    mstate_t     mstate = M_HUNT;
    int          mcount = 0;
    logic [15:0] exp_pix;
    logic        exp_lock;

    logic [127:0] fdata [CPF];

    int rh, rv, rframe;
    int pause_frame, pause_h, pause_v, pause_left;
    bit pause_done;
    int src_chunk, src_frame, inj_frame, inj_chunk, stall_frame, stall_chunk, stall_left;
    bit src_on, src_hold, stall_done, rst_req;
    bit last_active, last_pause;
    int last_h, last_v, last_rframe;
    logic last_ready;

    function automatic logic [15:0] fpix(input int p);
        logic [127:0] c;
        c = fdata[p / 8];
        return c[16*(p % 8) +: 16];
    endfunction

    task automatic model_push(input logic [127:0] d, input logic l);
        for (int i = 0; i < 8; i++) begin
            pix_t p;
            p.val  = d[16*i +: 16];
            p.last = l && (i == 7);
            mq.push_back(p);
        end
    endtask

    task automatic model_step(input bit ad, input int h, input int v, input bit xfer,
                              input logic [127:0] d, input logic l);
        bit   fs, fe, ok;
        pix_t p;
        exp_pix  = FILL;
        exp_lock = 1'b0;
        fs = ad && h == 0 && v == 0;
        fe = ad && h == W - 1 && v == H - 1;
        if (rst_req) begin
            mstate = M_HUNT;
            mq.delete();
            mcount = 0;
        end else begin
            case (mstate)
                M_HUNT: if (xfer && l) mstate = M_ARM;
                M_ARM: begin
                    if (fs && mq.size() > 0) begin
                        p = mq.pop_front();
                        exp_pix = p.val; exp_lock = 1'b1;
                        mstate = M_RUN;
                    end
                    if (xfer) model_push(d, l);
                end
                default: begin
                    ok = 1;
                    if (ad) begin
                        if (mq.size() == 0) begin
                            ok = 0;
                        end else begin
                            p = mq.pop_front();
                            exp_pix = p.val; exp_lock = 1'b1;
                            if (fe) begin
                                if (p.last) mstate = M_ARM;
                                else ok = 0;
                            end else if (p.last) begin
                                ok = 0;
                            end
                        end
                    end
                    if (!ok) begin
                        mstate = M_HUNT;
                        mq.delete();
                        if (mcount < 65535) mcount++;
                    end else if (xfer) begin
                        model_push(d, l);
                    end
                end
            endcase
        end
    endtask

    // One clock: drive at negedge, settle, update model, clock, check.
    task automatic tick();
        bit ad, xfer;
        sys_rst_pixel = rst_req;
        last_pause = (pause_left > 0);
        ad = !rst_req && !last_pause && rh < W && rv < H;
        active_draw = ad;
        h_count = 11'(rh);
        v_count = 10'(rv);
        if (src_on && stall_left == 0 &&
            (src_hold || mstate == M_RUN || $urandom_range(3) != 0)) begin
            chunk_tvalid = 1'b1;
            chunk_tdata  = fdata[src_chunk];
            chunk_tlast  = (src_chunk == CPF - 1) || (src_frame == inj_frame && src_chunk == inj_chunk);
        end else begin
            chunk_tvalid = 1'b0;
        end
        if (stall_left > 0) stall_left--;
        #1;
        last_ready = chunk_tready;
        xfer = chunk_tvalid && chunk_tready;
        src_hold = chunk_tvalid && !xfer;
        model_step(ad, rh, rv, xfer, chunk_tdata, chunk_tlast);
        last_active = ad; last_h = rh; last_v = rv; last_rframe = rframe;
        if (xfer)
            $display("xfer src_frame %0d chunk %0d tlast %0b raster f%0d (%0d,%0d)",
                     src_frame, src_chunk, chunk_tlast, rframe, rh, rv);
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        n_checks++;
        if (pixel_out !== exp_pix || pixel_locked !== exp_lock) begin
            n_fail++;
            $display("FAIL model_pixel f%0d (%0d,%0d): got %h/%b want %h/%b",
                     last_rframe, last_h, last_v, pixel_out, pixel_locked, exp_pix, exp_lock);
        end
        n_checks++;
        if (resync_count !== 16'(mcount)) begin
            n_fail++;
            $display("FAIL model_resync: got %0d want %0d", resync_count, mcount);
        end
        if (xfer) begin
            src_chunk++;
            if (src_chunk == CPF) begin src_chunk = 0; src_frame++; end
            if (!stall_done && src_frame == stall_frame && src_chunk == stall_chunk) begin
                stall_left = STALL_N; stall_done = 1;
            end
        end
        if (!rst_req) begin
            if (pause_left > 0) begin
                pause_left--;
            end else begin
                rh++;
                if (rh == HT) begin
                    rh = 0; rv++;
                    if (rv == VT) begin rv = 0; rframe++; end
                end
                if (!pause_done && rframe == pause_frame && rv == pause_v && rh == pause_h) begin
                    pause_left = PAUSE_N; pause_done = 1;
                end
            end
        end
    endtask

    task automatic start_test(input bit ramp);
        for (int k = 0; k < CPF; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (ramp) fdata[k][16*i +: 16] = 16'(8 * k + i);
                else      fdata[k][16*i +: 16] = 16'($urandom);
            end
        end
        rh = 0; rv = 0; rframe = 0;
        pause_frame = -1; pause_left = 0; pause_done = 0; pause_h = 0; pause_v = 0;
        src_chunk = 0; src_frame = 0; src_on = 0; src_hold = 0;
        inj_frame = -1; inj_chunk = -1; stall_frame = -1; stall_chunk = -1;
        stall_left = 0; stall_done = 0;
        rst_req = 1;
        tick();
        tick();
        rst_req = 0;
        src_on = 1;
    endtask

    task automatic check_timeout(input int want_frame, input string name);
        n_checks++;
        if (rframe < want_frame) begin
            n_fail++;
            $display("FAIL %s_timeout: reached frame %0d want %0d", name, rframe, want_frame);
        end
    endtask

    task automatic test_reset();
        start_test(1);
        n_checks++;
        if (pixel_out !== FILL || pixel_locked !== 1'b0 || resync_count !== 16'd0 || chunk_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got pix %h lock %b cnt %0d rdy %b want %h 0 0 1",
                     pixel_out, pixel_locked, resync_count, chunk_tready, FILL);
        end
    endtask

    task automatic test_stream_frame();
        start_test(1);
        for (int g = 0; g < GUARD && rframe < 3; g++) begin
            tick();
            if (last_active && last_rframe == 1) begin
                n_checks++;
                if (pixel_out !== 16'(last_v * W + last_h) || pixel_locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_pixel (%0d,%0d): got %h/%b want %h/1",
                             last_h, last_v, pixel_out, pixel_locked, 16'(last_v * W + last_h));
                end
            end else if (last_active && last_rframe == 0) begin
                n_checks++;
                if (pixel_locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_unlocked_f0: got %b want 0", pixel_locked);
                end
            end
        end
        check_timeout(3, "stream");
        n_checks++;
        if (resync_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stream_resync: got %0d want 0", resync_count);
        end
    endtask

    task automatic test_mid_frame_start();
        start_test(0);
        src_chunk = CPF / 2;
        for (int g = 0; g < GUARD && rframe < 2; g++) begin
            tick();
            if (last_active && last_rframe == 0) begin
                n_checks++;
                if (pixel_out !== FILL || pixel_locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midstart_fill: got %h/%b want %h/0", pixel_out, pixel_locked, FILL);
                end
            end else if (last_active && last_rframe == 1) begin
                n_checks++;
                if (pixel_out !== fpix(last_v * W + last_h) || pixel_locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midstart_pixel (%0d,%0d): got %h/%b want %h/1",
                             last_h, last_v, pixel_out, pixel_locked, fpix(last_v * W + last_h));
                end
            end
        end
        check_timeout(2, "midstart");
        n_checks++;
        if (resync_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midstart_resync: got %0d want 0", resync_count);
        end
    endtask

    task automatic test_underflow();
        start_test(0);
        stall_frame = 1;
        stall_chunk = int'($urandom_range(CPF - 2, 1));
        for (int g = 0; g < GUARD && rframe < 3; g++) begin
            tick();
            if (last_active && last_rframe == 1) begin
                n_checks++;
                if ((last_v * W + last_h) < 8 * stall_chunk) begin
                    if (pixel_locked !== 1'b1) begin
                        n_fail++;
                        $display("FAIL underflow_before: pixel %0d lock %b want 1", last_v * W + last_h, pixel_locked);
                    end
                end else if (pixel_locked !== 1'b0 || pixel_out !== FILL) begin
                    n_fail++;
                    $display("FAIL underflow_after: pixel %0d got %h/%b want %h/0",
                             last_v * W + last_h, pixel_out, pixel_locked, FILL);
                end
            end else if (last_active && last_rframe == 2) begin
                n_checks++;
                if (pixel_out !== fpix(last_v * W + last_h) || pixel_locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL underflow_relock (%0d,%0d): got %h/%b want %h/1",
                             last_h, last_v, pixel_out, pixel_locked, fpix(last_v * W + last_h));
                end
            end
        end
        check_timeout(3, "underflow");
        n_checks++;
        if (resync_count !== 16'd1) begin
            n_fail++;
            $display("FAIL underflow_resync: got %0d want 1", resync_count);
        end
    endtask

    task automatic test_early_tlast();
        start_test(0);
        inj_frame = 1;
        inj_chunk = int'($urandom_range(CPF - 2, 1));
        for (int g = 0; g < GUARD && rframe < 3; g++) begin
            tick();
            if (last_active && last_rframe == 1) begin
                n_checks++;
                if (pixel_locked !== ((last_v * W + last_h) <= 8 * inj_chunk + 7)) begin
                    n_fail++;
                    $display("FAIL tlast_lock pixel %0d: got %b want %b", last_v * W + last_h,
                             pixel_locked, (last_v * W + last_h) <= 8 * inj_chunk + 7);
                end
            end else if (last_active && last_rframe == 2) begin
                n_checks++;
                if (pixel_out !== fpix(last_v * W + last_h) || pixel_locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tlast_relock (%0d,%0d): got %h/%b want %h/1",
                             last_h, last_v, pixel_out, pixel_locked, fpix(last_v * W + last_h));
                end
            end
        end
        check_timeout(3, "tlast");
        n_checks++;
        if (resync_count !== 16'd1) begin
            n_fail++;
            $display("FAIL tlast_resync: got %0d want 1", resync_count);
        end
    endtask

    task automatic test_blanking_pause();
        int paused;
        start_test(0);
        paused = 0;
        pause_frame = 1;
        pause_v = int'($urandom_range(H - 1, 0));
        pause_h = 8 * int'($urandom_range(W / 8 - 1, 0)) + int'($urandom_range(7, 1));
        for (int g = 0; g < GUARD && rframe < 2; g++) begin
            tick();
            if (last_pause) begin
                paused++;
                n_checks++;
                if (last_ready !== 1'b0 || pixel_locked !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pause_hold: ready %b lock %b want 0 0", last_ready, pixel_locked);
                end
            end else if (last_active && last_rframe == 1) begin
                n_checks++;
                if (pixel_out !== fpix(last_v * W + last_h) || pixel_locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pause_pixel (%0d,%0d): got %h/%b want %h/1",
                             last_h, last_v, pixel_out, pixel_locked, fpix(last_v * W + last_h));
                end
            end
        end
        check_timeout(2, "pause");
        n_checks++;
        if (paused != PAUSE_N || resync_count !== 16'd0) begin
            n_fail++;
            $display("FAIL pause_summary: cycles %0d cnt %0d want %0d 0", paused, resync_count, PAUSE_N);
        end
    endtask

    task automatic test_reset_mid_run();
        int th, tv;
        start_test(0);
        inj_frame = 1;
        inj_chunk = int'($urandom_range(CPF - 2, 1));
        th = int'($urandom_range(W - 1, 1));
        tv = int'($urandom_range(H - 1, 0));
        for (int g = 0; g < GUARD && !(rframe == 2 && rh == th && rv == tv); g++) tick();
        check_timeout(2, "midrst");
        n_checks++;
        if (resync_count !== 16'd1 || pixel_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_before: cnt %0d lock %b want 1 1", resync_count, pixel_locked);
        end
        rst_req = 1;
        tick();
        rst_req = 0;
        n_checks++;
        if (pixel_out !== FILL || pixel_locked !== 1'b0 || chunk_tready !== 1'b1 || resync_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_after: pix %h lock %b rdy %b cnt %0d want %h 0 1 0",
                     pixel_out, pixel_locked, chunk_tready, resync_count, FILL);
        end
        for (int g = 0; g < GUARD && rframe < 4; g++) begin
            tick();
            if (last_active && last_rframe == 3) begin
                n_checks++;
                if (pixel_out !== fpix(last_v * W + last_h) || pixel_locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midrst_relock (%0d,%0d): got %h/%b want %h/1",
                             last_h, last_v, pixel_out, pixel_locked, fpix(last_v * W + last_h));
                end
            end
        end
        check_timeout(4, "midrst_relock");
    endtask

    initial begin
        @(negedge clk_pixel);
        test_reset();
        test_stream_frame();
        test_mid_frame_start();
        test_underflow();
        test_early_tlast();
        test_blanking_pause();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
